line_frame_timer: RTL

Line/frame timing generator that sits directly upstream of the pattern control FSM. On a start request it produces the `f_sync`, `sync`, `endLine` and `endFrame` strobes that drive the control block through each line and each frame. It also exports pixel and line position counters for the datapath. Line length follows the latched work mode: 4096 values in Regular mode, `PIX_PER_LINE` values in every test mode.

---
 rtl/line_frame_timer_if.sv | 26 ++
 rtl/line_frame_timer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/line_frame_timer_if.sv
// line_frame_timer_if: control and status bundle of the line/frame timing generator.
// master drives start/stop/Mode and observes the timing strobes and counters.
// slave is the timer side.
interface line_frame_timer_if;
    logic        start;
    logic        stop;
    logic [2:0]  Mode;
    logic        f_sync;
    logic        sync;
    logic        endLine;
    logic        endFrame;
    logic        busy;
    logic [11:0] pix_cnt;
    logic [9:0]  line_cnt;
    logic [2:0]  mode_q;

    modport master (
        output start, stop, Mode,
        input  f_sync, sync, endLine, endFrame, busy, pix_cnt, line_cnt, mode_q
    );

    modport slave (
        input  start, stop, Mode,
        output f_sync, sync, endLine, endFrame, busy, pix_cnt, line_cnt, mode_q
    );
endinterface

// File: rtl/line_frame_timer.sv
// line_frame_timer: line/frame timing generator feeding the pattern control FSM.
// Each line is one SYNC cycle, then len ACTIVE cycles (4096 in Regular mode 1,
// PIX_PER_LINE otherwise), then H_BLANK blanking cycles.
// Optional feature macro: LFT_FREERUN_EN. When it is defined, frames repeat
// back to back until stop; otherwise one frame is produced per start.
module line_frame_timer #(
    parameter int PIX_PER_LINE = 1290,
    parameter int LINES        = 64,
    parameter int H_BLANK      = 16
) (
    input logic               clk,
    input logic               rst_n,
    line_frame_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        BLANK
    } state_t;

    localparam logic [11:0] PIX_LAST   = 12'(PIX_PER_LINE - 1);
    localparam logic [11:0] REG_LAST   = 12'hFFF;
    localparam logic [9:0]  LINE_LAST  = 10'(LINES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(H_BLANK - 1);

    state_t      state_q, state_d;
    logic [11:0] pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic [7:0]  blank_q, blank_d;
    logic [2:0]  mode_lat_q, mode_lat_d;
    logic        sync_q, sync_d;
    logic        f_sync_q, f_sync_d;
    logic        end_line_q, end_line_d;
    logic        end_frame_q, end_frame_d;
    logic        busy_q, busy_d;
    logic [11:0] last_pix;

    assign last_pix = (mode_lat_q == 3'd1) ? REG_LAST : PIX_LAST;

    // Next-state, counter and strobe logic; strobes are derived from the next
    // state so that every output comes straight out of a flop.
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        line_d     = line_q;
        blank_d    = blank_q;
        mode_lat_d = mode_lat_q;

        if (bus.stop) begin
            state_d = IDLE;
            pix_d   = '0;
            line_d  = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && (bus.Mode != 3'd0)) begin
                        mode_lat_d = bus.Mode;
                        line_d     = '0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    pix_d   = '0;
                    state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (pix_q == last_pix) begin
                        pix_d   = '0;
                        blank_d = '0;
                        state_d = BLANK;
                    end else begin
                        pix_d = pix_q + 12'd1;
                    end
                end
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        blank_d = '0;
                        if (line_q == LINE_LAST) begin
                            line_d = '0;
`ifdef LFT_FREERUN_EN
                            mode_lat_d = bus.Mode;
                            state_d    = SYNC;
`else
                            state_d    = IDLE;
`endif
                        end else begin
                            line_d  = line_q + 10'd1;
                            state_d = SYNC;
                        end
                    end else begin
                        blank_d = blank_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sync_d      = (state_d == SYNC);
        f_sync_d    = sync_d && (line_d == '0);
        end_line_d  = (state_d == BLANK);
        end_frame_d = end_line_d && (line_d == LINE_LAST);
        busy_d      = (state_d != IDLE);
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            line_q      <= '0;
            blank_q     <= '0;
            mode_lat_q  <= '0;
            sync_q      <= 1'b0;
            f_sync_q    <= 1'b0;
            end_line_q  <= 1'b0;
            end_frame_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            blank_q     <= blank_d;
            mode_lat_q  <= mode_lat_d;
            sync_q      <= sync_d;
            f_sync_q    <= f_sync_d;
            end_line_q  <= end_line_d;
            end_frame_q <= end_frame_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sync     = sync_q;
    assign bus.f_sync   = f_sync_q;
    assign bus.endLine  = end_line_q;
    assign bus.endFrame = end_frame_q;
    assign bus.busy     = busy_q;
    assign bus.pix_cnt  = pix_q;
    assign bus.line_cnt = line_q;
    assign bus.mode_q   = mode_lat_q;

endmodule
